alu_execute: RTL and testbench

ALU_EXECUTE -- requirements
Module: alu_execute

---
 rtl/alu_execute_pkg.sv | 30 +++
 rtl/alu_execute_if.sv | 27 ++
 rtl/alu_execute_core.sv | 46 ++++
 rtl/alu_execute.sv | 101 ++++++++++
 tb/tb_alu_execute.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_execute_pkg.sv
// alu_execute_pkg: ALU operation codes and default widths shared with the ALU-control decoder
package defaultParametersPkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_SHAMT_WIDTH = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_BLTU = 4'b1110,
        ALU_BGEU = 4'b1111
    } alu_op_e;

    function automatic logic is_shift(input alu_op_e op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_execute_if.sv
// alu_execute_if: operation request / result handshake bundle for alu_execute
interface alu_execute_if
    import defaultParametersPkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  inValid;
    logic                  inReady;
    logic [3:0]            aluControlIn;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;
    logic                  flush;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] aluResult;
    logic                  branchTaken;

    modport master (
        output inValid, aluControlIn, operandA, operandB, flush, outReady,
        input  inReady, outValid, aluResult, branchTaken
    );

    modport slave (
        input  inValid, aluControlIn, operandA, operandB, flush, outReady,
        output inReady, outValid, aluResult, branchTaken
    );
endinterface

// File: rtl/alu_execute_core.sv
// alu_core: combinational arithmetic, logic, shift and compare datapath
module alu_core
    import defaultParametersPkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEFAULT_SHAMT_WIDTH
) (
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  taken
);
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   lt_s;
    logic                   lt_u;

    assign shamt = b[SHAMT_WIDTH-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // branch codes only drive taken; result stays zero for them
    always_comb begin
        result = '0;
        taken  = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result[0] = lt_s;
            ALU_SLTU: result[0] = lt_u;
            ALU_BEQ:  taken = a == b;
            ALU_BNE:  taken = a != b;
            ALU_BLT:  taken = lt_s;
            ALU_BGE:  taken = !lt_s;
            ALU_BLTU: taken = lt_u;
            ALU_BGEU: taken = !lt_u;
            default:  ;
        endcase
    end
endmodule

// File: rtl/alu_execute.sv
// alu_execute: registered ALU stage with valid/ready handshake; ALU_SERIAL_SHIFT_EN selects bit-serial shifts
module alu_execute
    import defaultParametersPkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEFAULT_SHAMT_WIDTH
) (
    input  logic         clk,
    input  logic         rstN,
    alu_execute_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;

    logic [0:0]             state;
    alu_op_e                op;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  core_result;
    logic                   core_taken;
    logic                   accept;
    logic                   go_serial;
    logic                   finish;
    logic [DATA_WIDTH-1:0]  finish_value;

    assign op           = alu_op_e'(bus.aluControlIn);
    assign shamt        = bus.operandB[SHAMT_WIDTH-1:0];
    assign bus.inReady  = state == IDLE && (!bus.outValid || bus.outReady);
    assign accept       = bus.inValid && bus.inReady && !bus.flush;

    alu_core #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_WIDTH(SHAMT_WIDTH)) u_core (
        .op     (op),
        .a      (bus.operandA),
        .b      (bus.operandB),
        .result (core_result),
        .taken  (core_taken)
    );

`ifdef ALU_SERIAL_SHIFT_EN
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SHAMT_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0]  work;
    alu_op_e                sop;

    function automatic logic [DATA_WIDTH-1:0] shift1(input alu_op_e o, input logic [DATA_WIDTH-1:0] x);
        return o == ALU_SLL ? x << 1 : o == ALU_SRL ? x >> 1 : {x[DATA_WIDTH-1], x[DATA_WIDTH-1:1]};
    endfunction

    // the accept cycle performs the first bit, so cnt holds the bits still to go
    assign go_serial    = accept && is_shift(op) && shamt > SHAMT_WIDTH'(1);
    assign finish       = state == SHIFT && cnt == SHAMT_WIDTH'(1);
    assign finish_value = shift1(sop, work);

    // serial shift sequencer: one bit per cycle, flush or reset abandons it
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            sop   <= ALU_SLL;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (go_serial) begin
            state <= SHIFT;
            cnt   <= shamt - SHAMT_WIDTH'(1);
            work  <= shift1(op, bus.operandA);
            sop   <= op;
        end else if (state == SHIFT) begin
            state <= finish ? IDLE : SHIFT;
            cnt   <= cnt - SHAMT_WIDTH'(1);
            work  <= shift1(sop, work);
        end
    end
`else
    assign state        = IDLE;
    assign go_serial    = 1'b0;
    assign finish       = 1'b0;
    assign finish_value = '0;
`endif

    // output register: flush wins, then serial completion, then a fresh accept, else drain
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus.outValid    <= 1'b0;
            bus.aluResult   <= '0;
            bus.branchTaken <= 1'b0;
        end else if (bus.flush) begin
            bus.outValid <= 1'b0;
        end else if (finish) begin
            bus.outValid    <= 1'b1;
            bus.aluResult   <= finish_value;
            bus.branchTaken <= 1'b0;
        end else if (accept && !go_serial) begin
            bus.outValid    <= 1'b1;
            bus.aluResult   <= core_result;
            bus.branchTaken <= core_taken;
        end else if (bus.outReady) begin
            bus.outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: directed-vector bench for alu_execute (both ALU_SERIAL_SHIFT_EN builds)
module tb_alu_execute;
    import defaultParametersPkg::*;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    alu_execute_if bus ();

    alu_execute dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.inValid      = 1'b1;
        bus.aluControlIn = op;
        bus.operandA     = a;
        bus.operandB     = b;
    endtask

    task automatic run_vec(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic et);
        drive(op, a, b);
        step();
        check({tag, ".valid"}, 32'(bus.outValid), 32'd1);
        check({tag, ".result"}, bus.aluResult, er);
        check({tag, ".taken"}, 32'(bus.branchTaken), 32'(et));
    endtask

    initial begin
        bus.inValid      = 1'b0;
        bus.aluControlIn = 4'd0;
        bus.operandA     = '0;
        bus.operandB     = '0;
        bus.flush        = 1'b0;
        bus.outReady     = 1'b1;
        step();
        check("rst.valid", 32'(bus.outValid), 32'd0);
        check("rst.result", bus.aluResult, 32'd0);
        check("rst.taken", 32'(bus.branchTaken), 32'd0);
        check("rst.ready", 32'(bus.inReady), 32'd1);
        rstN = 1'b1;
        step();

        run_vec("add_wrap", ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        run_vec("sub_wrap", ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        run_vec("and",      ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        run_vec("or",       ALU_OR,   32'h0F0F0000, 32'h00000F0F, 32'h0F0F0F0F, 1'b0);
        run_vec("xor",      ALU_XOR,  32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 1'b0);
        run_vec("sll1",     ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0);
        run_vec("srl0",     ALU_SRL,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0);
        run_vec("slt",      ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
        run_vec("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_vec("beq",      ALU_BEQ,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        run_vec("bne",      ALU_BNE,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        run_vec("blt",      ALU_BLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        run_vec("bltu",     ALU_BLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        run_vec("bge",      ALU_BGE,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        run_vec("bgeu",     ALU_BGEU, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        bus.inValid = 1'b0;
        step();
        check("drain.valid", 32'(bus.outValid), 32'd0);

        drive(ALU_SRA, 32'h80000000, 32'h00000024);
        step();
        bus.inValid = 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
        for (int i = 0; i < 3; i++) begin
            check("sra.busy_ready", 32'(bus.inReady), 32'd0);
            check("sra.busy_valid", 32'(bus.outValid), 32'd0);
            step();
        end
`endif
        check("sra.valid", 32'(bus.outValid), 32'd1);
        check("sra.result", bus.aluResult, 32'hF8000000);
        check("sra.taken", 32'(bus.branchTaken), 32'd0);
        step();

        bus.outReady = 1'b0;
        drive(ALU_ADD, 32'd10, 32'd20);
        step();
        drive(ALU_XOR, 32'h1, 32'h3);
        for (int i = 0; i < 3; i++) begin
            check("stall.ready", 32'(bus.inReady), 32'd0);
            check("stall.valid", 32'(bus.outValid), 32'd1);
            check("stall.result", bus.aluResult, 32'd30);
            step();
        end
        bus.outReady = 1'b1;
        #1;
        check("release.ready", 32'(bus.inReady), 32'd1);
        step();
        bus.inValid = 1'b0;
        check("b2b.valid", 32'(bus.outValid), 32'd1);
        check("b2b.result", bus.aluResult, 32'd2);
        step();
        check("b2b.drain", 32'(bus.outValid), 32'd0);

        bus.flush = 1'b1;
        drive(ALU_SLTU, 32'd1, 32'd2);
        step();
        bus.flush = 1'b0;
        bus.inValid = 1'b0;
        check("flush_acc.valid", 32'(bus.outValid), 32'd0);
        check("flush_acc.ready", 32'(bus.inReady), 32'd1);

`ifdef ALU_SERIAL_SHIFT_EN
        drive(ALU_SRL, 32'h80000000, 32'h00000008);
        step();
        bus.inValid = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_shift.valid", 32'(bus.outValid), 32'd0);
        check("flush_shift.ready", 32'(bus.inReady), 32'd1);
        repeat (8) step();
        check("flush_shift.quiet", 32'(bus.outValid), 32'd0);
`endif

        bus.outReady = 1'b0;
        drive(ALU_BEQ, 32'd7, 32'd7);
        step();
        bus.inValid = 1'b0;
        check("pre_rst.taken", 32'(bus.branchTaken), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check("arst.valid", 32'(bus.outValid), 32'd0);
        check("arst.taken", 32'(bus.branchTaken), 32'd0);
        step();
        rstN = 1'b1;
        bus.outReady = 1'b1;

`ifdef ALU_SERIAL_SHIFT_EN
        drive(ALU_SLL, 32'h00000001, 32'h0000000A);
        step();
        bus.inValid = 1'b0;
        step();
        check("mid_shift.ready", 32'(bus.inReady), 32'd0);
        #2;
        rstN = 1'b0;
        #1;
        check("rst_shift.valid", 32'(bus.outValid), 32'd0);
        check("rst_shift.result", bus.aluResult, 32'd0);
        check("rst_shift.ready", 32'(bus.inReady), 32'd1);
        step();
        rstN = 1'b1;
`endif

        run_vec("post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0);
        bus.inValid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
